// File: rtl/sigma_s_icp_accumulator.sv
// Frame-level sum of squared ICP residuals and correspondence count, 3-cycle latency.
// Build with `define SIGMA_S_ICP_SAT_EN for saturating accumulators and overflow reporting.
module sigma_s_icp_accumulator #(
    parameter int DATA_BW = 24,
    parameter int CNT_BW  = 19
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_frame_start,
    input  logic                   i_frame_end,
    input  logic                   i_valid,
    input  logic                   i_corresp_valid,
    input  logic [DATA_BW-1:0]     i_diff,
    output logic                   o_frame_end,
    output logic [4*DATA_BW-1:0]   o_sigma_s_icp,
    output logic [CNT_BW-1:0]      o_corresp_count,
    output logic                   o_overflow
);

    localparam int SQ_BW  = 2 * DATA_BW;
    localparam int ACC_BW = 4 * DATA_BW;

    logic               take_d1, start_d1, end_d1;
    logic [DATA_BW-1:0] diff_d1;
    logic [DATA_BW-1:0] abs_d1;

    logic               take_d2, start_d2, end_d2;
    logic [SQ_BW-1:0]   sq_d2;

    logic [ACC_BW-1:0]  acc, acc_base, add_term, acc_next;
    logic [CNT_BW-1:0]  cnt, cnt_base, cnt_next;

    // NOTE: sequential state uses non-blocking assignments so each stage samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            take_d1  <= 1'b0;
            start_d1 <= 1'b0;
            end_d1   <= 1'b0;
            diff_d1  <= '0;
        end else begin
            take_d1  <= i_valid & i_corresp_valid;
            start_d1 <= i_frame_start;
            end_d1   <= i_frame_end;
            diff_d1  <= i_diff;
        end
    end

    // The most negative code maps to 2^(DATA_BW-1), which still fits unsigned in DATA_BW bits.
    always_comb begin
        abs_d1 = diff_d1[DATA_BW-1] ? (DATA_BW'(0) - diff_d1) : diff_d1;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            take_d2  <= 1'b0;
            start_d2 <= 1'b0;
            end_d2   <= 1'b0;
            sq_d2    <= '0;
        end else begin
            take_d2  <= take_d1;
            start_d2 <= start_d1;
            end_d2   <= end_d1;
            sq_d2    <= SQ_BW'(abs_d1) * SQ_BW'(abs_d1);
        end
    end

    // NOTE: every combinational output gets a default first, so no latch can be inferred.
    always_comb begin
        acc_base = start_d2 ? '0 : acc;
        cnt_base = start_d2 ? '0 : cnt;
        add_term = take_d2 ? ACC_BW'(sq_d2) : '0;
    end

`ifdef SIGMA_S_ICP_SAT_EN
    logic [ACC_BW:0]    acc_sum;
    logic [CNT_BW:0]    cnt_sum;
    logic               ovf, ovf_next;

    // A carry out of the widened add marks saturation; the frame flag restarts with the frame.
    always_comb begin
        acc_sum  = {1'b0, acc_base} + {1'b0, add_term};
        cnt_sum  = {1'b0, cnt_base} + (CNT_BW+1)'(take_d2);
        acc_next = acc_sum[ACC_BW] ? '1 : acc_sum[ACC_BW-1:0];
        cnt_next = cnt_sum[CNT_BW] ? '1 : cnt_sum[CNT_BW-1:0];
        ovf_next = (start_d2 ? 1'b0 : ovf) | acc_sum[ACC_BW] | cnt_sum[CNT_BW];
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ovf        <= 1'b0;
            o_overflow <= 1'b0;
        end else begin
            ovf <= ovf_next;
            if (end_d2) begin
                o_overflow <= ovf_next;
            end
        end
    end
`else
    always_comb begin
        acc_next = acc_base + add_term;
        cnt_next = cnt_base + CNT_BW'(take_d2);
    end

    assign o_overflow = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            acc             <= '0;
            cnt             <= '0;
            o_frame_end     <= 1'b0;
            o_sigma_s_icp   <= '0;
            o_corresp_count <= '0;
        end else begin
            acc         <= acc_next;
            cnt         <= cnt_next;
            o_frame_end <= end_d2;
            if (end_d2) begin
                o_sigma_s_icp   <= acc_next;
                o_corresp_count <= cnt_next;
            end
        end
    end

endmodule
